// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared state encoding and default sizes for the output classifier
package nn_pkg;

  localparam int DEF_ALU_WIDTH  = 12;
  localparam int DEF_OUTPUT_LEN = 10;
  localparam int DEF_IDX_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_e;

endpackage

// File: rtl/argmax_tracker.sv
// rtl/argmax_tracker.sv - running best score/index with strict signed compare
module argmax_tracker #(
  parameter int ALU_WIDTH = 12,
  parameter int IDX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 valid,
  input  logic                 load_first,
  input  logic [ALU_WIDTH-1:0] score,
  input  logic [IDX_WIDTH-1:0] idx,
  output logic [ALU_WIDTH-1:0] best_score,
  output logic [IDX_WIDTH-1:0] best_idx
);

  logic [ALU_WIDTH-1:0] best_score_q, best_score_d;
  logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    if (clear) begin
      best_score_d = '0;
      best_idx_d   = '0;
    end else if (valid && (load_first || ($signed(score) > $signed(best_score_q)))) begin
      best_score_d = score;
      best_idx_d   = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_score_q <= '0;
      best_idx_q   <= '0;
    end else begin
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
    end
  end

  assign best_score = best_score_q;
  assign best_idx   = best_idx_q;

endmodule

// File: rtl/output_classifier.sv
// rtl/output_classifier.sv - argmax over final-layer neurons with valid/ready result
// Optional per-neuron score buffer with rd_idx/rd_score ports: OUTPUT_CLASSIFIER_SCORE_BUF_EN.
module output_classifier
  import nn_pkg::*;
#(
  parameter int ALU_WIDTH  = DEF_ALU_WIDTH,
  parameter int OUTPUT_LEN = DEF_OUTPUT_LEN,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [ALU_WIDTH-1:0] in_score,
  input  logic                 in_act,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic [IDX_WIDTH-1:0] result_class,
  output logic [ALU_WIDTH-1:0] result_score,
  output logic [IDX_WIDTH-1:0] result_act_cnt,
  output logic                 overflow
`ifdef OUTPUT_CLASSIFIER_SCORE_BUF_EN
  ,
  input  logic [IDX_WIDTH-1:0] rd_idx,
  output logic [ALU_WIDTH-1:0] rd_score
`endif
);

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0] act_cnt_q, act_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 result_valid_q, result_valid_d;
  logic                 accept_start;
  logic                 strobe;

  // A start in REPORT only counts when it rides along with the handshake.
  assign accept_start = start && ((state_q != REPORT) || result_ready);
  assign strobe       = (state_q == COLLECT) && in_valid && !start;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    act_cnt_d      = act_cnt_q;
    overflow_d     = overflow_q;
    result_valid_d = result_valid_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = COLLECT;
      end
      COLLECT: begin
        if (strobe) begin
          act_cnt_d = act_cnt_q + IDX_WIDTH'(in_act);
          if (cnt_q == IDX_WIDTH'(OUTPUT_LEN - 1)) begin
            cnt_d          = '0;
            state_d        = REPORT;
            result_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      REPORT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = start ? COLLECT : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_start) begin
      cnt_d      = '0;
      act_cnt_d  = '0;
      overflow_d = 1'b0;
    end else if (in_valid && (state_q != COLLECT)) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      act_cnt_q      <= '0;
      overflow_q     <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      act_cnt_q      <= act_cnt_d;
      overflow_q     <= overflow_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Tracker registers double as the result fields: frozen outside COLLECT until the next start.
  argmax_tracker #(
    .ALU_WIDTH (ALU_WIDTH),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept_start),
    .valid      (strobe),
    .load_first (cnt_q == '0),
    .score      (in_score),
    .idx        (cnt_q),
    .best_score (result_score),
    .best_idx   (result_class)
  );

  assign result_valid   = result_valid_q;
  assign result_act_cnt = act_cnt_q;
  assign overflow       = overflow_q;

`ifdef OUTPUT_CLASSIFIER_SCORE_BUF_EN
  logic [ALU_WIDTH-1:0] buf_q [OUTPUT_LEN];
  logic [ALU_WIDTH-1:0] buf_d [OUTPUT_LEN];

  always_comb begin
    buf_d = buf_q;
    if (strobe) buf_d[cnt_q] = in_score;
  end

  // Deliberately not cleared on start so earlier scores stay readable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUTPUT_LEN; i++) buf_q[i] <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign rd_score = (rd_idx < IDX_WIDTH'(OUTPUT_LEN)) ? buf_q[rd_idx] : '0;
`endif

endmodule

// File: tb/tb_output_classifier.sv
// tb/tb_output_classifier.sv - directed self-checking bench for output_classifier
module tb_output_classifier;
  import nn_pkg::*;

  localparam int AW = DEF_ALU_WIDTH;
  localparam int IW = DEF_IDX_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [AW-1:0] in_score = '0;
  logic          in_act = 1'b0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [IW-1:0] result_class;
  logic [AW-1:0] result_score;
  logic [IW-1:0] result_act_cnt;
  logic          overflow;
`ifdef OUTPUT_CLASSIFIER_SCORE_BUF_EN
  logic [IW-1:0] rd_idx = '0;
  logic [AW-1:0] rd_score;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  output_classifier dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .in_score       (in_score),
    .in_act         (in_act),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_class   (result_class),
    .result_score   (result_score),
    .result_act_cnt (result_act_cnt),
    .overflow       (overflow)
`ifdef OUTPUT_CLASSIFIER_SCORE_BUF_EN
    ,
    .rd_idx         (rd_idx),
    .rd_score       (rd_score)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int score, input logic act);
    in_valid = 1'b1;
    in_score = AW'(score);
    in_act   = act;
    cycle();
    in_valid = 1'b0;
    in_act   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int v, input int cls, input int sc, input int act);
    check({tag, ".valid"}, int'(result_valid), v);
    check({tag, ".class"}, int'(result_class), cls);
    check({tag, ".score"}, int'($signed(result_score)), sc);
    check({tag, ".act"}, int'(result_act_cnt), act);
  endtask

  int s_max[10]  = '{3, -2, 7, 1, 0, 5, -8, 2, 6, 4};
  int s_rst[10]  = '{9, 3, 9, -1, 0, 2, 8, 7, 1, 5};
  int a_rst[10]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 1};

  initial begin
    // reset
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_result("reset", 0, 0, 0, 0);
    check("reset.overflow", int'(overflow), 0);

    // ordinary max
    pulse_start();
    for (int i = 0; i < 9; i++) send(s_max[i], 1'b1);
    check("max.valid_before_last", int'(result_valid), 0);
    send(s_max[9], 1'b1);
    check_result("max", 1, 2, 7, 10);
    result_ready = 1'b1;
    cycle();
    result_ready = 1'b0;
    check("max.valid_after_hs", int'(result_valid), 0);
    check("max.class_held", int'(result_class), 2);

    // ties and negatives
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      if (i == 4 || i == 8) send(-1, 1'b1);
      else send(-5, 1'b0);
    end
    check_result("tie", 1, 4, -1, 2);

    // backpressure with a stray strobe in REPORT
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        in_valid = 1'b1;
        in_score = AW'(777);
      end
      cycle();
      in_valid = 1'b0;
      check("bp.valid", int'(result_valid), 1);
      check("bp.class", int'(result_class), 4);
      check("bp.score", int'($signed(result_score)), -1);
    end
    check("bp.overflow", int'(overflow), 1);
    result_ready = 1'b1;
    cycle();
    result_ready = 1'b0;
    check("bp.valid_after_hs", int'(result_valid), 0);
    check("bp.overflow_sticky", int'(overflow), 1);
    check("bp.class_held", int'(result_class), 4);

    // restart mid-collect; start with simultaneous in_valid discards the strobe
    pulse_start();
    check("restart.overflow_cleared", int'(overflow), 0);
    for (int i = 0; i < 6; i++) send(100, 1'b1);
    start    = 1'b1;
    in_valid = 1'b1;
    in_score = AW'(500);
    cycle();
    start    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(s_rst[i], a_rst[i]);
      if (i == 3) begin
        cycle();
        cycle();
      end
    end
    check_result("restart", 1, 0, 9, 3);
    check("restart.overflow", int'(overflow), 0);

    // back-to-back: start with the handshake
    result_ready = 1'b1;
    start        = 1'b1;
    cycle();
    result_ready = 1'b0;
    start        = 1'b0;
    check("b2b.valid_dropped", int'(result_valid), 0);
    for (int i = 0; i < 10; i++) send(i - 20, 1'b0);
    check_result("b2b", 1, 9, -11, 0);
`ifdef OUTPUT_CLASSIFIER_SCORE_BUF_EN
    rd_idx = 4'd3;
    #1;
    check("buf.idx3", int'($signed(rd_score)), -17);
    rd_idx = 4'd12;
    #1;
    check("buf.out_of_range", int'($signed(rd_score)), 0);
`endif
    result_ready = 1'b1;
    cycle();
    result_ready = 1'b0;

    // reset mid-collect
    pulse_start();
    for (int i = 0; i < 5; i++) send(30 + i, 1'b1);
    check("midrst.act_before", int'(result_act_cnt), 5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_result("midrst", 0, 0, 0, 0);
    check("midrst.overflow", int'(overflow), 0);
`ifdef OUTPUT_CLASSIFIER_SCORE_BUF_EN
    for (int i = 0; i < 10; i++) begin
      rd_idx = IW'(i);
      #1;
      check("midrst.buf", int'(rd_score), 0);
    end
`endif
    // after reset the block is IDLE: a strobe is overflow, not collected
    send(42, 1'b1);
    check("idle.overflow", int'(overflow), 1);
    check("idle.act", int'(result_act_cnt), 0);
    check("idle.valid", int'(result_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/output_classifier.md
Name: output_classifier

Overview:
- Downstream stage of the layer-4 compute engine.
- Consumes the OUTPUT_LEN final-layer neuron results (signed accumulator score plus activated bit), one per strobe.
- Tracks the running argmax and presents the classified digit to the testbench/host with a valid/ready handshake.
- Replaces ad-hoc in-engine printing and `$finish` with a synthesizable result register.

Parameters:
- ALU_WIDTH, 12, width of the signed accumulator score per output neuron
- OUTPUT_LEN, 10, number of output neurons (classes) per inference
- IDX_WIDTH, 4, width of class index; must satisfy 2^IDX_WIDTH >= OUTPUT_LEN

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; arms collection for a new inference
- in_valid  input  1  a neuron result is presented this cycle
- in_score  input  ALU_WIDTH  signed (two's complement) accumulator value of current neuron
- in_act  input  1  activated (sign) bit of current neuron
- result_valid  output  1  classification available
- result_ready  input  1  consumer accepts result
- result_class  output  IDX_WIDTH  index of winning neuron
- result_score  output  ALU_WIDTH  score of winning neuron
- result_act_cnt  output  IDX_WIDTH  number of neurons with in_act=1
- overflow  output  1  sticky: in_valid seen while not collecting

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; all outputs 0; internal neuron counter 0.
- States: IDLE, COLLECT, REPORT.
- IDLE:
  - start=1 goes to COLLECT; clears counter, best_score, best_idx, act_cnt.
  - in_valid in IDLE sets overflow; the data is discarded.
- COLLECT, each cycle with in_valid=1:
  - Neuron index = counter; counter increments.
  - act_cnt += in_act.
  - First neuron (counter=0) loads best unconditionally.
  - Later neurons replace best only if in_score > best_score (strict signed compare). Ties therefore keep the lowest index.
  - The strobe with counter = OUTPUT_LEN-1 moves to REPORT.
  - result_valid rises on the cycle after that strobe: latency 1 cycle from last accepted score.
  - in_valid=0 cycles stall collection; there is no timeout.
- REPORT:
  - result_valid=1. result_class, result_score and result_act_cnt are held stable until handshake.
  - result_valid&result_ready moves to IDLE; result_valid drops next cycle. Result fields keep their last values until the next start.
  - in_valid in REPORT sets overflow and is discarded.
- start boundaries:
  - start during COLLECT: restart, clearing counter and best, staying in COLLECT. An in_valid in the same cycle is discarded.
  - start during REPORT with result_ready=1: the handshake completes and the block goes directly to COLLECT (new inference armed).
  - start during REPORT with result_ready=0: ignored.
- overflow: cleared only by rst or by start.
- Width rules:
  - Counter is IDX_WIDTH bits and never wraps, because it is cleared on the terminal strobe.
  - act_cnt saturates at OUTPUT_LEN by construction.

Optional Feature:
- Macro: OUTPUT_CLASSIFIER_SCORE_BUF_EN.
- With the macro defined:
  - Adds ports rd_idx (input, IDX_WIDTH) and rd_score (output, ALU_WIDTH).
  - Each accepted in_score is written into an OUTPUT_LEN-entry buffer at the neuron index.
  - rd_score = buffer[rd_idx] combinationally.
  - rd_idx >= OUTPUT_LEN returns 0.
  - Buffer is cleared on rst only (not on start), so stale entries remain visible until overwritten.
- Without the macro: no buffer and no extra ports; argmax behaviour is identical.

Decomposition:
- Shared package (nn_pkg): state encoding constants (IDLE/COLLECT/REPORT), OUTPUT_LEN, ALU_WIDTH, IDX_WIDTH defaults, reused by compute module and bench.
- One natural sub-module: argmax_tracker (best_score/best_idx registers plus strict signed compare, with load_first and clear inputs).
- The score buffer stays inline under the macro.

Test Plan:
- Ordinary max: rst, start, scores [3,-2,7,1,0,5,-8,2,6,4], all in_act=1 → one cycle after 10th strobe result_valid=1, class=2, score=7, act_cnt=10.
- Tie and negatives: scores all -5 except idx 4 and 8 = -1; in_act only on 4 and 8 → class=4, score=-1, act_cnt=2.
- Backpressure: result_ready held 0 for 20 cycles, then 1 → outputs stable throughout, result_valid drops the cycle after the handshake. Extra in_valid during the hold sets overflow=1.
- Restart mid-collect: 6 scores, then start, then 10 fresh scores with max 9 at idx 0 → class=0, score=9 (first 6 ignored).
- Back-to-back: start asserted together with result_ready in REPORT → immediate COLLECT; the second inference reports correctly with no lost strobe after that cycle.
- Reset mid-operation: rst during COLLECT after 5 strobes → all outputs 0, IDLE. With OUTPUT_CLASSIFIER_SCORE_BUF_EN defined, rd_score for idx 0..9 reads 0; otherwise check that the ports are absent.
